// File: rtl/ext_bus_arbiter.sv
// Two-requester arbiter and sequencer for the AS2650 multiplexed external bus.
// Each granted request runs ADDR_HI -> ADDR_LO -> DATA (HOLD_CYCLES) -> END.
module ext_bus_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter bit          PRIO_FIXED  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    input  logic        req0_we,
    input  logic [1:0]  req0_space,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    input  logic        req1_we,
    input  logic [1:0]  req1_space,
    output logic        resp0_valid,
    output logic [7:0]  resp0_rdata,
    output logic        resp1_valid,
    output logic [7:0]  resp1_rdata,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic [7:0]  bus_in,
    output logic        le_hi,
    output logic        le_lo,
    output logic        oe_n,
    output logic        we_n,
    output logic        iod,
    output logic        ioc,
    output logic        busy
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_END
    } state_t;

    state_t      state;
    logic [3:0]  hold_cnt;
    logic        last_served;   // 1 = req1 was served most recently
    logic        own;
    logic [7:0]  addr_lo_q;
    logic [7:0]  wdata_q;
    logic        we_q;

    logic        grant1;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_we;
    logic [1:0]  sel_space;

    always_comb begin
        if (req0_valid && req1_valid) grant1 = PRIO_FIXED ? 1'b0 : ~last_served;
        else                          grant1 = req1_valid;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_space = grant1 ? req1_space : req0_space;
    end

    assign req0_ready = (state == S_IDLE) && req0_valid && !grant1;
    assign req1_ready = (state == S_IDLE) && req1_valid && grant1;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            last_served <= 1'b1;
            own         <= 1'b0;
            addr_lo_q   <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            bus_out     <= '0;
            bus_oe      <= 1'b0;
            le_hi       <= 1'b0;
            le_lo       <= 1'b0;
            oe_n        <= 1'b1;
            we_n        <= 1'b1;
            iod         <= 1'b0;
            ioc         <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_rdata <= '0;
            resp1_rdata <= '0;
        end else begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        own         <= grant1;
                        last_served <= grant1;
                        addr_lo_q   <= sel_addr[7:0];
                        wdata_q     <= sel_wdata;
                        we_q        <= sel_we;
                        bus_out     <= sel_addr[15:8];
                        bus_oe      <= 1'b1;
                        le_hi       <= 1'b1;
                        iod         <= (sel_space == 2'b01);
                        ioc         <= (sel_space == 2'b10);
                        state       <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    le_hi   <= 1'b0;
                    le_lo   <= 1'b1;
                    bus_out <= addr_lo_q;
                    state   <= S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    le_lo    <= 1'b0;
                    hold_cnt <= HOLD_LOAD;
                    if (we_q) begin
                        bus_out <= wdata_q;
                        bus_oe  <= 1'b1;
                        we_n    <= 1'b0;
                    end else begin
                        bus_oe  <= 1'b0;
                        oe_n    <= 1'b0;
                    end
                    state <= S_DATA;
                end
                S_DATA: begin
                    if (hold_cnt == 4'd0) begin
                        oe_n <= 1'b1;
                        we_n <= 1'b1;
                        if (own) resp1_valid <= 1'b1;
                        else     resp0_valid <= 1'b1;
                        if (!we_q && own)  resp1_rdata <= bus_in;
                        if (!we_q && !own) resp0_rdata <= bus_in;
                        state <= S_END;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                S_END: begin
                    bus_out <= '0;
                    bus_oe  <= 1'b0;
                    iod     <= 1'b0;
                    ioc     <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Bench for ext_bus_arbiter: a round-robin instance (HOLD_CYCLES=1) and a fixed-priority
// instance (HOLD_CYCLES=3) are checked every cycle against a transaction-offset model.
module tb_ext_bus_arbiter;

    logic clk;
    logic rst_n;

    logic [1:0]       req0_valid, req1_valid, req0_we, req1_we;
    logic [1:0][15:0] req0_addr, req1_addr;
    logic [1:0][7:0]  req0_wdata, req1_wdata, bus_in;
    logic [1:0][1:0]  req0_space, req1_space;
    logic [1:0]       req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [1:0][7:0]  resp0_rdata, resp1_rdata, bus_out;
    logic [1:0]       bus_oe, le_hi, le_lo, oe_n, we_n, iod, ioc, busy;

    ext_bus_arbiter #(.HOLD_CYCLES(1), .PRIO_FIXED(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]), .req0_addr(req0_addr[0]),
        .req0_wdata(req0_wdata[0]), .req0_we(req0_we[0]), .req0_space(req0_space[0]),
        .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]), .req1_addr(req1_addr[0]),
        .req1_wdata(req1_wdata[0]), .req1_we(req1_we[0]), .req1_space(req1_space[0]),
        .resp0_valid(resp0_valid[0]), .resp0_rdata(resp0_rdata[0]),
        .resp1_valid(resp1_valid[0]), .resp1_rdata(resp1_rdata[0]),
        .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0]),
        .le_hi(le_hi[0]), .le_lo(le_lo[0]), .oe_n(oe_n[0]), .we_n(we_n[0]),
        .iod(iod[0]), .ioc(ioc[0]), .busy(busy[0])
    );

    ext_bus_arbiter #(.HOLD_CYCLES(3), .PRIO_FIXED(1'b1)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]), .req0_addr(req0_addr[1]),
        .req0_wdata(req0_wdata[1]), .req0_we(req0_we[1]), .req0_space(req0_space[1]),
        .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]), .req1_addr(req1_addr[1]),
        .req1_wdata(req1_wdata[1]), .req1_we(req1_we[1]), .req1_space(req1_space[1]),
        .resp0_valid(resp0_valid[1]), .resp0_rdata(resp0_rdata[1]),
        .resp1_valid(resp1_valid[1]), .resp1_rdata(resp1_rdata[1]),
        .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1]),
        .le_hi(le_hi[1]), .le_lo(le_lo[1]), .oe_n(oe_n[1]), .we_n(we_n[1]),
        .iod(iod[1]), .ioc(ioc[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: a transaction is described by its offset k from the handshake edge.
    bit         m_busy [2];
    int         m_k    [2];
    int         m_own  [2];
    int         m_last [2];
    logic [15:0] m_addr [2];
    logic [7:0]  m_wdata[2];
    logic        m_we   [2];
    logic [1:0]  m_space[2];
    logic [7:0]  m_rdata[2][2];
    bit          hs     [2][2];
    int          log_q0[$];
    int          log_q1[$];

    typedef struct {
        int          inst;
        int          req;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic [1:0]  space;
        logic [7:0]  bin;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        logic        exp_iod;
        logic        exp_ioc;
        int          exp_strobe;
        int          exp_lat;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];

    function automatic int hold_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int pick(int i, logic v0, logic v1);
        if (v0 && v1) return (i == 1) ? 0 : ((m_last[i] == 0) ? 1 : 0);
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_k[i] = 0; m_own[i] = 0; m_last[i] = 1;
            m_addr[i] = '0; m_wdata[i] = '0; m_we[i] = 0; m_space[i] = '0;
            m_rdata[i][0] = '0; m_rdata[i][1] = '0;
            hs[i][0] = 0; hs[i][1] = 0;
        end
    endtask

    task automatic set_req(int i, int r, logic v, logic [15:0] a, logic [7:0] d, logic w, logic [1:0] s);
        if (r == 0) begin
            req0_valid[i] = v; req0_addr[i] = a; req0_wdata[i] = d; req0_we[i] = w; req0_space[i] = s;
        end else begin
            req1_valid[i] = v; req1_addr[i] = a; req1_wdata[i] = d; req1_we[i] = w; req1_space[i] = s;
        end
    endtask

    task automatic check_all();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int g, h, k;
            logic in_data, in_end, x_oe;
            logic [7:0] x_out;
            h = hold_of(i);
            k = m_busy[i] ? m_k[i] : 0;
            g = m_busy[i] ? -1 : pick(i, req0_valid[i], req1_valid[i]);
            in_data = (k >= 3) && (k <= 2 + h);
            in_end  = (k == 3 + h);
            x_oe  = (k == 1) || (k == 2) || ((in_data || in_end) && m_we[i]);
            x_out = (k == 1) ? m_addr[i][15:8] : (k == 2) ? m_addr[i][7:0] : m_wdata[i];
            chk("req0_ready", i, req0_ready[i], g == 0);
            chk("req1_ready", i, req1_ready[i], g == 1);
            chk("busy", i, busy[i], m_busy[i]);
            chk("le_hi", i, le_hi[i], k == 1);
            chk("le_lo", i, le_lo[i], k == 2);
            chk("oe_n", i, oe_n[i], !(in_data && !m_we[i]));
            chk("we_n", i, we_n[i], !(in_data && m_we[i]));
            chk("bus_oe", i, bus_oe[i], x_oe);
            chk("iod", i, iod[i], m_busy[i] && m_space[i] == 2'b01);
            chk("ioc", i, ioc[i], m_busy[i] && m_space[i] == 2'b10);
            chk("resp0_valid", i, resp0_valid[i], in_end && m_own[i] == 0);
            chk("resp1_valid", i, resp1_valid[i], in_end && m_own[i] == 1);
            chk("resp0_rdata", i, resp0_rdata[i], m_rdata[i][0]);
            chk("resp1_rdata", i, resp1_rdata[i], m_rdata[i][1]);
            if (x_oe) chk("bus_out", i, bus_out[i], x_out);
            if (req0_ready[i] && req0_valid[i]) begin
                if (i == 0) log_q0.push_back(0); else log_q1.push_back(0);
            end
            if (req1_ready[i] && req1_valid[i]) begin
                if (i == 0) log_q0.push_back(1); else log_q1.push_back(1);
            end
        end
    endtask

    task automatic advance_all();
        for (int i = 0; i < 2; i++) begin
            int g, h;
            h = hold_of(i);
            if (!m_busy[i]) begin
                g = pick(i, req0_valid[i], req1_valid[i]);
                if (g >= 0) begin
                    m_busy[i] = 1; m_k[i] = 1; m_own[i] = g; m_last[i] = g; hs[i][g] = 1;
                    m_addr[i]  = (g == 1) ? req1_addr[i]  : req0_addr[i];
                    m_wdata[i] = (g == 1) ? req1_wdata[i] : req0_wdata[i];
                    m_we[i]    = (g == 1) ? req1_we[i]    : req0_we[i];
                    m_space[i] = (g == 1) ? req1_space[i] : req0_space[i];
                end
            end else begin
                if (m_k[i] == 2 + h && !m_we[i]) m_rdata[i][m_own[i]] = bus_in[i];
                m_k[i]++;
                if (m_k[i] > 3 + h) m_busy[i] = 0;
            end
        end
    endtask

    task automatic finish_cycle();
        check_all();
        @(posedge clk);
        advance_all();
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2; i++) begin
            req0_valid[i] = 1'b0;
            req1_valid[i] = 1'b0;
        end
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (!busy[0] && !busy[1] && !m_busy[0] && !m_busy[1]) break;
        end
        chk("quiesce", 0, {14'b0, busy}, 16'h0);
    endtask

    task automatic drive_random();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                logic v;
                logic [15:0] a;
                v = (r == 0) ? req0_valid[i] : req1_valid[i];
                case ($urandom_range(0, 7))
                    0:       a = 16'h0000;
                    1:       a = 16'hFFFF;
                    default: a = 16'($urandom);
                endcase
                if (hs[i][r] || !v) begin
                    set_req(i, r, $urandom_range(0, 9) < 4, a, 8'($urandom), 1'($urandom), 2'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    if (r == 0) req0_valid[i] = 1'b0; else req1_valid[i] = 1'b0;
                end
                hs[i][r] = 0;
            end
            bus_in[i] = 8'($urandom);
        end
    endtask

    task automatic apply(vec_t v);
        int n, strobes, h;
        bit got;
        logic rdy, rv;
        logic [7:0] rd;
        h = hold_of(v.inst);
        set_req(v.inst, v.req, 1'b1, v.addr, v.wdata, v.we, v.space);
        bus_in[v.inst] = v.bin ^ 8'h5A;
        n = -1; strobes = 0; got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            rdy = (v.req == 1) ? req1_ready[v.inst] : req0_ready[v.inst];
            rv  = (v.req == 1) ? resp1_valid[v.inst] : resp0_valid[v.inst];
            rd  = (v.req == 1) ? resp1_rdata[v.inst] : resp0_rdata[v.inst];
            if (n < 0 && rdy) n = 0;
            else if (n >= 0) n++;
            if (n == 1) begin
                chk("vec_le_hi", v.inst, le_hi[v.inst], 1'b1);
                chk("vec_addr_hi", v.inst, bus_out[v.inst], v.exp_hi);
                chk("vec_iod", v.inst, iod[v.inst], v.exp_iod);
                chk("vec_ioc", v.inst, ioc[v.inst], v.exp_ioc);
            end
            if (n == 2) begin
                chk("vec_le_lo", v.inst, le_lo[v.inst], 1'b1);
                chk("vec_addr_lo", v.inst, bus_out[v.inst], v.exp_lo);
            end
            if (n >= 1 && (!oe_n[v.inst] || !we_n[v.inst])) strobes++;
            if (rv) begin
                got = 1;
                chk("vec_latency", v.inst, 16'(n), 16'(v.exp_lat));
                chk("vec_strobe_len", v.inst, 16'(strobes), 16'(v.exp_strobe));
                chk("vec_end_oe", v.inst, bus_oe[v.inst], v.we);
                if (!v.we) chk("vec_rdata", v.inst, rd, v.exp_rdata);
            end
            finish_cycle();
            if (n == 0) set_req(v.inst, v.req, 1'b0, ~v.addr, ~v.wdata, ~v.we, ~v.space);
            bus_in[v.inst] = (n + 1 == 2 + h) ? v.bin : (v.bin ^ 8'h5A);
        end
        chk("vec_done", v.inst, got, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first, second;
        bit switched;

        vecs[0] = '{0, 0, 16'h12A5, 8'h00, 1'b0, 2'b00, 8'h3C, 8'h12, 8'hA5, 1'b0, 1'b0, 1, 4, 8'h3C};
        vecs[1] = '{0, 1, 16'h8001, 8'h5A, 1'b1, 2'b01, 8'h00, 8'h80, 8'h01, 1'b1, 1'b0, 1, 4, 8'h00};
        vecs[2] = '{1, 0, 16'hFFFF, 8'h00, 1'b0, 2'b10, 8'hA7, 8'hFF, 8'hFF, 1'b0, 1'b1, 3, 6, 8'hA7};
        vecs[3] = '{1, 1, 16'h0000, 8'hC3, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3, 6, 8'h00};
        vecs[4] = '{0, 0, 16'hBEEF, 8'h11, 1'b1, 2'b10, 8'h00, 8'hBE, 8'hEF, 1'b0, 1'b1, 1, 4, 8'h00};
        vecs[5] = '{0, 1, 16'h0000, 8'h00, 1'b0, 2'b11, 8'hFE, 8'h00, 8'h00, 1'b0, 1'b0, 1, 4, 8'hFE};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(i, 0, 1'b0, 16'h0, 8'h0, 1'b0, 2'b00);
            set_req(i, 1, 1'b0, 16'h0, 8'h0, 1'b0, 2'b00);
            bus_in[i] = 8'h00;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Both requesters held valid: round-robin alternates, fixed priority starves req1.
        for (int i = 0; i < 2; i++) begin
            set_req(i, 0, 1'b1, 16'h1000, 8'h11, 1'b0, 2'b00);
            set_req(i, 1, 1'b1, 16'h2000, 8'h22, 1'b1, 2'b00);
        end
        log_q0.delete();
        log_q1.delete();
        for (int c = 0; c < 120; c++) begin
            cycle();
            if (log_q0.size() >= 4 && log_q1.size() >= 4) break;
        end
        wait_idle();
        chk("rr_count", 0, log_q0.size() >= 4, 1'b1);
        chk("fx_count", 1, log_q1.size() >= 4, 1'b1);
        for (int k = 0; k < 4 && k < log_q0.size(); k++) chk("rr_grant", 0, 16'(log_q0[k]), 16'(k % 2));
        for (int k = 0; k < 4 && k < log_q1.size(); k++) chk("fx_grant", 1, 16'(log_q1[k]), 16'h0);

        for (int t = 0; t < 6; t++) apply(vecs[t]);
        wait_idle();

        // Read then write from req0 with no gap between them.
        set_req(0, 0, 1'b1, 16'h2468, 8'h00, 1'b0, 2'b00);
        bus_in[0] = 8'h99;
        first = -1; second = -1; switched = 0;
        for (int c = 0; c < 40 && second < 0; c++) begin
            @(negedge clk);
            if (req0_ready[0]) begin
                if (first < 0) first = cyc; else second = cyc;
            end
            chk("b2b_no_strobe_overlap", 0, oe_n[0] || we_n[0], 1'b1);
            chk("b2b_no_le_overlap", 0, le_hi[0] && le_lo[0], 1'b0);
            finish_cycle();
            if (first >= 0 && !switched) begin
                set_req(0, 0, 1'b1, 16'h1357, 8'hE1, 1'b1, 2'b00);
                switched = 1;
            end
        end
        chk("b2b_gap", 0, 16'(second - first), 16'd5);
        wait_idle();

        // Reset in the middle of a write data phase.
        set_req(0, 0, 1'b1, 16'h4321, 8'h77, 1'b1, 2'b00);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (m_busy[0] && m_k[0] == 3) break;
        end
        chk("pre_rst_we_n", 0, we_n[0], 1'b0);
        set_req(0, 0, 1'b1, 16'h0101, 8'h00, 1'b0, 2'b00);
        set_req(0, 1, 1'b1, 16'h0202, 8'h00, 1'b0, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we_n", 0, we_n[0], 1'b1);
        chk("rst_bus_oe", 0, bus_oe[0], 1'b0);
        chk("rst_resp0", 0, resp0_valid[0], 1'b0);
        chk("rst_busy", 0, busy[0], 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", 0, req0_ready[0], 1'b1);
        chk("post_rst_ready1", 0, req1_ready[0], 1'b0);
        finish_cycle();
        wait_idle();

        drive_random();
        for (int c = 0; c < 1500; c++) begin
            cycle();
            drive_random();
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
